// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  typedef logic [31:0] enc_t;
  typedef logic [31:0] val_t;

  localparam enc_t NOP_ENC          = 32'h0000_0000;
  localparam val_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    val_t pc;
    enc_t enc;
    logic fault;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic val_t align_pc(input val_t pc);
    return pc & ~val_t'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head is visible combinationally.
// Push and pop may coincide at any occupancy, including full.
module fetch_queue #(
  parameter type          T     = logic [31:0],
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  T                 mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PCs, in-order imem requests, response queue to decode,
// redirect flush. Define FETCH_PERF_CNT_EN to add the perfFetched/perfStall/perfFlushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter val_t        RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  input  logic        imemRspErr,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        decValid,
  input  logic        decReady,
  output logic [31:0] decEnc,
  output logic [31:0] decPc,
  output logic        decFault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perfFetched,
  output logic [31:0] perfStall,
  output logic [31:0] perfFlushed
`endif
);

  localparam int unsigned QCNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned OCNT_W = $clog2(MAX_OUTST + 1);

  val_t              pc_q, pc_d;
  logic [OCNT_W-1:0] drop_q, drop_d;
  logic [QCNT_W-1:0] q_count;
  logic [OCNT_W-1:0] outst;
  logic              q_empty;
  fetch_entry_t      q_head, rsp_entry;
  val_t              tag_head;
  logic              req_fire, rsp_drop, rsp_keep, dec_pop;

  // Credit rule: every in-flight request owns a queue slot, so responses never overflow.
  assign imemReqValid = rst_n && !redirectValid
                        && ((32'(q_count) + 32'(outst)) < QDEPTH)
                        && (32'(outst) < MAX_OUTST);
  assign imemReqAddr  = pc_q;
  assign req_fire     = imemReqValid && imemReqReady;

  // A response is discarded while stale requests are draining or when a redirect lands with it.
  assign rsp_drop  = imemRspValid && (redirectValid || (drop_q != '0));
  assign rsp_keep  = imemRspValid && !rsp_drop;
  assign dec_pop   = !q_empty && decReady;
  assign rsp_entry = '{pc: tag_head, enc: (imemRspErr ? NOP_ENC : imemRspData), fault: imemRspErr};

  fetch_queue #(.T(fetch_entry_t), .DEPTH(QDEPTH)) u_rsp_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirectValid),
    .push_i  (rsp_keep),
    .data_i  (rsp_entry),
    .pop_i   (dec_pop),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (),
    .empty_o (q_empty)
  );

  // Tag FIFO occupancy is the in-flight count; it pops on every response, kept or dropped.
  fetch_queue #(.T(val_t), .DEPTH(MAX_OUTST)) u_tag_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (imemRspValid),
    .head_o  (tag_head),
    .count_o (outst),
    .full_o  (),
    .empty_o ()
  );

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirectValid) begin
      pc_d   = align_pc(redirectPc);
      drop_d = outst - OCNT_W'(imemRspValid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_drop) drop_d = drop_q - OCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    decValid = !q_empty;
    decPc    = '0;
    decEnc   = NOP_ENC;
    decFault = 1'b0;
    if (!q_empty) begin
      decPc    = q_head.pc;
      decEnc   = q_head.enc;
      decFault = q_head.fault;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flushed_q, flushed_d;

  // An entry popped in the redirect cycle was delivered, so it counts as fetched, not flushed.
  always_comb begin
    fetched_d = fetched_q + 32'(dec_pop);
    stall_d   = stall_q + 32'(decReady && q_empty);
    flushed_d = flushed_q + 32'(rsp_drop);
    if (redirectValid) flushed_d = flushed_d + 32'(q_count) - 32'(dec_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
      flushed_q <= flushed_d;
    end
  end

  assign perfFetched = fetched_q;
  assign perfStall   = stall_q;
  assign perfFlushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: epoch-based reference model, randomized memory and decoder,
// a table of redirect vectors and hand-written multi-cycle sequences.
module tb_fetch_unit;

  localparam int QDEPTH    = 4;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReqValid, imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRspValid, imemRspErr;
  logic [31:0] imemRspData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decValid, decReady, decFault;
  logic [31:0] decEnc, decPc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetched, perfStall, perfFlushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRspValid  (imemRspValid),
    .imemRspData   (imemRspData),
    .imemRspErr    (imemRspErr),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .decValid      (decValid),
    .decReady      (decReady),
    .decEnc        (decEnc),
    .decPc         (decPc),
    .decFault      (decFault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perfFetched   (perfFetched),
    .perfStall     (perfStall),
    .perfFlushed   (perfFlushed)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] enc; logic fault; } entry_t;
  typedef struct { logic [31:0] addr; logic err; int due; } mreq_t;
  typedef struct { logic [31:0] target; logic [31:0] first; logic [31:0] second; } redir_vec_t;

  // Reference model: requests carry the epoch they were issued in; a redirect opens a new epoch.
  flight_t     m_flight[$];
  entry_t      m_q[$];
  logic [31:0] m_pc;
  int          m_epoch;
  logic [31:0] m_fetched, m_stall, m_flushed;

  mreq_t       mem_q[$];
  entry_t      got[$];
  logic [31:0] fire_addrs[$];

  logic        k_ready, k_dec_ready, k_rv;
  logic [31:0] k_rpc;
  int          lat_min, lat_max, rsp_gap_pct, err_pct;
  logic        err_addr_en;
  logic [31:0] err_addr;

  int checks, errors, cyc, fires;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hDEAD_BEEF) + 32'h1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pop(input string name, input int idx, input logic [31:0] pc,
                           input logic [31:0] enc, input logic fault);
    if (got.size() <= idx) begin
      check({name, "_count"}, got.size(), idx + 1);
    end else begin
      check({name, "_pc"}, got[idx].pc, pc);
      check({name, "_enc"}, got[idx].enc, enc);
      check({name, "_fault"}, got[idx].fault, fault);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance model and memory.
  task automatic step();
    mreq_t       m;
    flight_t     f;
    logic        rsp, rerr, exp_req;
    logic [31:0] rdata;
    imemReqReady  = k_ready;
    decReady      = k_dec_ready;
    redirectValid = k_rv;
    redirectPc    = k_rpc;
    rsp   = 1'b0;
    rerr  = 1'b0;
    rdata = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom_range(99)) >= rsp_gap_pct) begin
      m     = mem_q.pop_front();
      rsp   = 1'b1;
      rdata = mem_word(m.addr);
      rerr  = m.err;
    end
    imemRspValid = rsp;
    imemRspData  = rdata;
    imemRspErr   = rerr;
    #1;
    exp_req = !k_rv && (m_q.size() + m_flight.size() < QDEPTH) && (m_flight.size() < MAX_OUTST);
    check("imemReqValid", imemReqValid, exp_req);
    check("imemReqAddr", imemReqAddr, m_pc);
    check("decValid", decValid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("decPc", decPc, m_q[0].pc);
      check("decEnc", decEnc, m_q[0].enc);
      check("decFault", decFault, m_q[0].fault);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perfFetched", perfFetched, m_fetched);
    check("perfStall", perfStall, m_stall);
    check("perfFlushed", perfFlushed, m_flushed);
`endif
    if (imemReqValid && imemReqReady) begin
      fires++;
      fire_addrs.push_back(imemReqAddr);
      mem_q.push_back('{addr: imemReqAddr,
                        err: (err_addr_en && imemReqAddr == err_addr) || int'($urandom_range(99)) < err_pct,
                        due: cyc + int'($urandom_range(lat_max, lat_min))});
    end
    if (decValid && decReady) got.push_back('{pc: decPc, enc: decEnc, fault: decFault});

    if (k_dec_ready && m_q.size() == 0) m_stall++;
    if (k_dec_ready && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_fetched++;
    end
    if (rsp) begin
      if (m_flight.size() == 0) begin
        check("rsp_has_request", m_flight.size(), 1);
      end else begin
        f = m_flight.pop_front();
        if (k_rv || f.epoch != m_epoch) m_flushed++;
        else m_q.push_back('{pc: f.addr, enc: (rerr ? 32'h0 : mem_word(f.addr)), fault: rerr});
      end
    end
    if (k_rv) begin
      m_flushed += m_q.size();
      m_q.delete();
      m_epoch++;
      m_pc = k_rpc & ~32'h3;
    end else if (exp_req && k_ready) begin
      m_flight.push_back('{addr: m_pc, epoch: m_epoch});
      m_pc += 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Memory is reset together with the fetch unit, so its pending responses vanish too.
  task automatic do_reset();
    rst_n         = 1'b0;
    imemReqReady  = 1'b0;
    imemRspValid  = 1'b0;
    imemRspData   = 32'h0;
    imemRspErr    = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    decReady      = 1'b0;
    k_rv          = 1'b0;
    mem_q.delete();
    m_flight.delete();
    m_q.delete();
    got.delete();
    fire_addrs.delete();
    m_pc      = 32'h0;
    m_epoch   = 0;
    m_fetched = 0;
    m_stall   = 0;
    m_flushed = 0;
    @(posedge clk);
    #2;
    check("rst_imemReqValid", imemReqValid, 0);
    check("rst_decValid", decValid, 0);
    check("rst_decEnc", decEnc, 0);
    check("rst_decPc", decPc, 0);
    check("rst_decFault", decFault, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perfFetched", perfFetched, 0);
    check("rst_perfStall", perfStall, 0);
    check("rst_perfFlushed", perfFlushed, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_vec_t rvec[4];
    int         n0, f0, bad;
    rvec[0] = '{target: 32'h0000_0203, first: 32'h0000_0200, second: 32'h0000_0204};
    rvec[1] = '{target: 32'hFFFF_FFFC, first: 32'hFFFF_FFFC, second: 32'h0000_0000};
    rvec[2] = '{target: 32'h0000_0101, first: 32'h0000_0100, second: 32'h0000_0104};
    rvec[3] = '{target: 32'h7FFF_FFFE, first: 32'h7FFF_FFFC, second: 32'h8000_0000};

    checks = 0; errors = 0; cyc = 0; fires = 0;
    lat_min = 1; lat_max = 1; rsp_gap_pct = 0; err_pct = 0;
    err_addr_en = 1'b0; err_addr = 32'h0;
    k_ready = 1'b1; k_dec_ready = 1'b1; k_rpc = 32'h0;

    // Sequential stream from reset with a fault at 0x8, then steady-state throughput.
    do_reset();
    err_addr_en = 1'b1; err_addr = 32'h8;
    repeat (12) step();
    check_pop("t1_first", 0, 32'h0, mem_word(32'h0), 1'b0);
    check_pop("t1_second", 1, 32'h4, mem_word(32'h4), 1'b0);
    check_pop("t4_fault", 2, 32'h8, 32'h0, 1'b1);
    check_pop("t4_after", 3, 32'hC, mem_word(32'hC), 1'b0);
    err_addr_en = 1'b0;
    n0 = got.size();
    repeat (10) step();
    check("t1_throughput", got.size() - n0, 10);

    // Decoder stalled from reset: credit allows exactly QDEPTH requests, then no loss on release.
    do_reset();
    k_dec_ready = 1'b0;
    f0 = fires;
    repeat (12) step();
    check("t2_stall_fires", fires - f0, QDEPTH);
    check("t2_req_blocked", imemReqValid, 0);
    k_dec_ready = 1'b1;
    repeat (30) step();
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i].pc != 32'(4 * i)) bad++;
    check("t2_seq_count_ok", got.size() >= 20, 1);
    check("t2_no_loss", bad, 0);

    // Redirect with two requests in flight: both responses dropped.
    lat_min = 3; lat_max = 3;
    for (int n = 0; n < 20 && m_flight.size() != 2; n++) step();
    k_rv = 1'b1; k_rpc = 32'h100;
    step();
    k_rv = 1'b0;
    got.delete();
    repeat (15) step();
    check_pop("t3_target", 0, 32'h100, mem_word(32'h100), 1'b0);

    // Table of redirect targets: alignment and PC wrap.
    lat_min = 1; lat_max = 3;
    foreach (rvec[i]) begin
      k_rv = 1'b1; k_rpc = rvec[i].target;
      step();
      k_rv = 1'b0;
      f0 = fire_addrs.size();
      for (int n = 0; n < 20 && fire_addrs.size() < f0 + 2; n++) step();
      if (fire_addrs.size() >= f0 + 2) begin
        check("t5_first_addr", fire_addrs[f0], rvec[i].first);
        check("t5_second_addr", fire_addrs[f0 + 1], rvec[i].second);
      end else begin
        check("t5_fire_timeout", fire_addrs.size(), f0 + 2);
      end
    end

    // Redirect while a response and a pop coincide, then a second redirect: last one wins.
    lat_min = 1; lat_max = 1;
    repeat (8) step();
    k_rv = 1'b1; k_rpc = 32'h4000;
    step();
    k_rpc = 32'h8000;
    step();
    k_rv = 1'b0;
    got.delete();
    repeat (12) step();
    check_pop("t6_target", 0, 32'h8000, mem_word(32'h8000), 1'b0);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i].pc < 32'h8000 || got[i].pc >= 32'h9000) bad++;
    check("t6_only_second_stream", bad, 0);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 4; rsp_gap_pct = 25; err_pct = 6;
    for (int i = 0; i < 3000; i++) begin
      k_ready     = ($urandom_range(3) != 0);
      k_dec_ready = ($urandom_range(2) != 0);
      k_rv        = ($urandom_range(39) == 0);
      k_rpc       = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step();
    end
    k_rv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
